signed_calc_seq: RTL

Parametrised, multi-cycle signed two's-complement calculator. It is the successor to the combinational 3-bit add/subtract block and adds multiply and divide. Add/sub complete in one iteration. Multiply (shift-add) and divide (restoring) iterate over WIDTH cycles on operand magnitudes. The block is driven by a start/busy/done handshake and sits between operand registers and the display/result path of the calculator.

---
 rtl/signed_calc_seq_if.sv | 27 ++
 rtl/signed_calc_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/signed_calc_seq_if.sv
// Handshake and operand/result bundle for the sequential signed calculator.
interface signed_calc_seq_if #(
   parameter int WIDTH = 3
);
   logic                   start;
   logic [1:0]             op;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     result;
   logic [WIDTH-1:0]       remainder;
   logic                   ovf;
   logic                   div_by_zero;

   // Operand/request side (operand registers / test driver)
   modport master (
      output start, op, a, b,
      input  busy, done, result, remainder, ovf, div_by_zero
   );

   // Calculator side
   modport slave (
      input  start, op, a, b,
      output busy, done, result, remainder, ovf, div_by_zero
   );
endinterface

// File: rtl/signed_calc_seq.sv
// Multi-cycle signed calculator: add/sub in one step, shift-add multiply and
// restoring divide on operand magnitudes over WIDTH iterations.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after completion
// SETUP | add/sub and divide-by-zero finish; mul/div load magnitudes
// RUN   | one shift-add / restoring-divide step per cycle, cnt counts down
module signed_calc_seq #(
   parameter int WIDTH = 3
) (
   input  logic            clk,
   input  logic            rst,
   signed_calc_seq_if.slave bus
);
   localparam int W  = WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;

   logic [W-1:0]     a_r, b_r;
   logic [1:0]       op_r;

   logic [2*W-1:0]   acc, mcand;
   logic [W-1:0]     mplier;
   logic [W-1:0]     dq, rem;
   logic [W:0]       dvsr;

   logic             done_r, ovf_r, dbz_r;
   logic [2*W-1:0]   result_r;
   logic [W-1:0]     remainder_r;

   logic [W:0]       a_ext, b_ext, ma, mb, sum;
   logic [2*W-1:0]   acc_nxt, qext;
   logic [W:0]       trial, diff;
   logic             q_bit;
   logic [W-1:0]     rem_nxt, dq_nxt;
   logic             neg;

   // Magnitudes, add/sub sum and one iteration step of mul/div
   always_comb begin
      a_ext   = {a_r[W-1], a_r};
      b_ext   = {b_r[W-1], b_r};
      ma      = a_r[W-1] ? -a_ext : a_ext;
      mb      = b_r[W-1] ? -b_ext : b_ext;
      sum     = (op_r == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
      neg     = a_r[W-1] ^ b_r[W-1];
      acc_nxt = mplier[0] ? (acc + mcand) : acc;
      trial   = {rem, dq[W-1]};
      q_bit   = (trial >= dvsr);
      diff    = trial - dvsr;
      rem_nxt = q_bit ? diff[W-1:0] : trial[W-1:0];
      dq_nxt  = {dq[W-2:0], q_bit};
      qext    = {{W{1'b0}}, dq_nxt};
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = SETUP;
         SETUP: begin
            if (op_r == OP_MUL || (op_r == OP_DIV && b_r != '0))
               state_nxt = RUN;
            else
               state_nxt = IDLE;
         end
         RUN:   if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Operand capture, iteration datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         op_r        <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         dq          <= '0;
         rem         <= '0;
         dvsr        <= '0;
         done_r      <= 1'b0;
         ovf_r       <= 1'b0;
         dbz_r       <= 1'b0;
         result_r    <= '0;
         remainder_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r  <= bus.a;
                  b_r  <= bus.b;
                  op_r <= bus.op;
               end
            end
            SETUP: begin
               cnt <= CW'(W - 1);
               case (op_r)
                  OP_ADD, OP_SUB: begin
                     result_r    <= {{(W-1){sum[W]}}, sum};
                     ovf_r       <= sum[W] ^ sum[W-1];
                     remainder_r <= '0;
                     dbz_r       <= 1'b0;
                     done_r      <= 1'b1;
                  end
                  OP_MUL: begin
                     acc    <= '0;
                     mcand  <= {{(W-1){1'b0}}, ma};
                     mplier <= mb[W-1:0];
                  end
                  default: begin
                     if (b_r == '0) begin
                        result_r    <= '0;
                        remainder_r <= a_r;
                        ovf_r       <= 1'b0;
                        dbz_r       <= 1'b1;
                        done_r      <= 1'b1;
                     end else begin
                        dq   <= ma[W-1:0];
                        rem  <= '0;
                        dvsr <= mb;
                     end
                  end
               endcase
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (op_r == OP_MUL) begin
                  acc    <= acc_nxt;
                  mcand  <= {mcand[2*W-2:0], 1'b0};
                  mplier <= {1'b0, mplier[W-1:1]};
                  if (cnt == '0) begin
                     result_r    <= neg ? -acc_nxt : acc_nxt;
                     remainder_r <= '0;
                     ovf_r       <= 1'b0;
                     dbz_r       <= 1'b0;
                     done_r      <= 1'b1;
                  end
               end else begin
                  rem <= rem_nxt;
                  dq  <= dq_nxt;
                  if (cnt == '0) begin
                     result_r    <= neg ? -qext : qext;
                     remainder_r <= a_r[W-1] ? -rem_nxt : rem_nxt;
                     ovf_r       <= 1'b0;
                     dbz_r       <= 1'b0;
                     done_r      <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_r;
   assign bus.result      = result_r;
   assign bus.remainder   = remainder_r;
   assign bus.ovf         = ovf_r;
   assign bus.div_by_zero = dbz_r;
endmodule
